// File: rtl/cpu_types_pkg.sv
// Shared pipeline types for the sequencing controller: register index, controller
// state and the bundle of pipeline-register controls it drives.
package cpu_types_pkg;

   typedef logic [4:0] regbits_t;

   typedef enum logic [1:0] {
      RUN    = 2'd0,
      DWAIT  = 2'd1,
      HALTED = 2'd2
   } hcu_state_t;

   typedef struct packed {
      logic pc_en;
      logic ifid_en;
      logic idex_en;
      logic exmem_en;
      logic memwb_en;
      logic flush_ifid;
      logic flush_idex;
      logic flush_exmem;
   } hcu_ctrl_t;

   localparam hcu_ctrl_t CTRL_NONE     = hcu_ctrl_t'(8'b0000_0000);
   localparam hcu_ctrl_t CTRL_ADVANCE  = hcu_ctrl_t'(8'b1111_1000);
   localparam hcu_ctrl_t CTRL_LOADUSE  = hcu_ctrl_t'(8'b0001_1010);
   localparam hcu_ctrl_t CTRL_REDIRECT = hcu_ctrl_t'(8'b1000_1111);
   localparam hcu_ctrl_t CTRL_DRETIRE  = hcu_ctrl_t'(8'b0000_1001);

   // Register 0 is hardwired, so a load targeting it never creates a dependency.
   function automatic logic load_use(input logic     memren_ex,
                                     input regbits_t regwrite_ex,
                                     input regbits_t rs_id,
                                     input regbits_t rt_id);
      return memren_ex && (regwrite_ex != '0) &&
             ((regwrite_ex == rs_id) || (regwrite_ex == rt_id));
   endfunction

endpackage

// File: rtl/hazard_control_unit_sat_counter.sv
// Saturating up-counter with asynchronous clear; holds at all-ones instead of wrapping.
module sat_counter #(
   parameter int W = 32
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic         inc_i,
   output logic [W-1:0] count_o
);

   logic [W-1:0] count_q;
   logic [W-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (inc_i && (count_q != {W{1'b1}})) begin
         count_d = count_q + {{(W-1){1'b0}}, 1'b1};
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count_o = count_q;

endmodule

// File: rtl/hazard_control_unit.sv
// Pipeline sequencing controller: priority decode of halt, data-memory waits,
// redirects and load-use hazards into register enables, flushes and PC write.
module hazard_control_unit
   import cpu_types_pkg::*;
#(
   parameter int CNT_W = 32
) (
   input  logic             CLK,
   input  logic             nRST,
   input  logic             ihit,
   input  logic             dhit,
   input  logic             dmemren_mem,
   input  logic             dmemwen_mem,
   input  logic             memren_ex,
   input  logic [4:0]       regwrite_ex,
   input  logic [4:0]       rs_id,
   input  logic [4:0]       rt_id,
   input  logic             redirect_mem,
   input  logic             halt_wb,
   output logic             ifid_en,
   output logic             idex_en,
   output logic             exmem_en,
   output logic             memwb_en,
   output logic             flush_ifid,
   output logic             flush_idex,
   output logic             flush_exmem,
   output logic             pc_en,
   output logic             halt,
   output logic [CNT_W-1:0] stall_cycles
);

   hcu_state_t state_q;
   hcu_state_t state_d;
   hcu_ctrl_t  ctrl;
   logic       memreq;
   logic       adv;
   logic       loaduse;
   logic       stall_inc;

   assign memreq  = dmemren_mem | dmemwen_mem;
   assign adv     = ihit & ~memreq;
   assign loaduse = load_use(memren_ex, regwrite_ex, rs_id, rt_id);

   // Outputs are Mealy; nRST gates them so the pipeline is frozen during reset.
   always_comb begin
      ctrl    = CTRL_NONE;
      state_d = state_q;
      if (!nRST) begin
         ctrl = CTRL_NONE;
      end else if (state_q == HALTED) begin
         state_d = HALTED;
      end else if (halt_wb) begin
         state_d = HALTED;
      end else if (memreq) begin
         if (dhit) begin
            // Retire the access into MEM/WB and bubble EX/MEM; ID/EX holds the EX op.
            ctrl    = CTRL_DRETIRE;
            state_d = RUN;
         end else begin
            state_d = DWAIT;
         end
      end else begin
         state_d = RUN;
         if (adv) begin
            if (redirect_mem) begin
               ctrl = CTRL_REDIRECT;
            end else if (loaduse) begin
               ctrl = CTRL_LOADUSE;
            end else begin
               ctrl = CTRL_ADVANCE;
            end
         end
      end
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_q <= RUN;
      end else begin
         state_q <= state_d;
      end
   end

   assign pc_en       = ctrl.pc_en;
   assign ifid_en     = ctrl.ifid_en;
   assign idex_en     = ctrl.idex_en;
   assign exmem_en    = ctrl.exmem_en;
   assign memwb_en    = ctrl.memwb_en;
   assign flush_ifid  = ctrl.flush_ifid;
   assign flush_idex  = ctrl.flush_idex;
   assign flush_exmem = ctrl.flush_exmem;
   assign halt        = (state_q == HALTED);

   // The cycle that enters HALTED is not counted as a stall.
   assign stall_inc = (state_q != HALTED) && (state_d != HALTED) && !ctrl.pc_en;

   sat_counter #(
      .W(CNT_W)
   ) u_stall_cnt (
      .clk_i  (CLK),
      .rst_ni (nRST),
      .inc_i  (stall_inc),
      .count_o(stall_cycles)
   );

endmodule

// File: tb/tb_hazard_control_unit.sv
// Directed bench for hazard_control_unit: a 32-bit and a 4-bit counter instance share
// stimulus; a spec-level model is compared every cycle, plus literal expectations.
module tb_hazard_control_unit;

   logic       CLK = 1'b0;
   logic       nRST;
   logic       ihit, dhit, dmemren_mem, dmemwen_mem, memren_ex, redirect_mem, halt_wb;
   logic [4:0] regwrite_ex, rs_id, rt_id;

   logic        a_ifid, a_idex, a_exmem, a_memwb, a_fifid, a_fidex, a_fexmem, a_pc, a_halt;
   logic        b_ifid, b_idex, b_exmem, b_memwb, b_fifid, b_fidex, b_fexmem, b_pc, b_halt;
   logic [31:0] a_cnt;
   logic [3:0]  b_cnt;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 CLK = ~CLK;

   hazard_control_unit #(.CNT_W(32)) dut_a (
      .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit),
      .dmemren_mem(dmemren_mem), .dmemwen_mem(dmemwen_mem), .memren_ex(memren_ex),
      .regwrite_ex(regwrite_ex), .rs_id(rs_id), .rt_id(rt_id),
      .redirect_mem(redirect_mem), .halt_wb(halt_wb),
      .ifid_en(a_ifid), .idex_en(a_idex), .exmem_en(a_exmem), .memwb_en(a_memwb),
      .flush_ifid(a_fifid), .flush_idex(a_fidex), .flush_exmem(a_fexmem),
      .pc_en(a_pc), .halt(a_halt), .stall_cycles(a_cnt));

   hazard_control_unit #(.CNT_W(4)) dut_b (
      .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit),
      .dmemren_mem(dmemren_mem), .dmemwen_mem(dmemwen_mem), .memren_ex(memren_ex),
      .regwrite_ex(regwrite_ex), .rs_id(rs_id), .rt_id(rt_id),
      .redirect_mem(redirect_mem), .halt_wb(halt_wb),
      .ifid_en(b_ifid), .idex_en(b_idex), .exmem_en(b_exmem), .memwb_en(b_memwb),
      .flush_ifid(b_fifid), .flush_idex(b_fidex), .flush_exmem(b_fexmem),
      .pc_en(b_pc), .halt(b_halt), .stall_cycles(b_cnt));

   // Output vector order: {pc_en, ifid, idex, exmem, memwb, flush_ifid, flush_idex, flush_exmem}
   wire [7:0] outs_a = {a_pc, a_ifid, a_idex, a_exmem, a_memwb, a_fifid, a_fidex, a_fexmem};
   wire [7:0] outs_b = {b_pc, b_ifid, b_idex, b_exmem, b_memwb, b_fifid, b_fidex, b_fexmem};

   task automatic check(input string name, input longint act, input longint exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   bit     m_halted;
   longint m_stalls;

   function automatic logic [7:0] model_out();
      logic memreq, adv, lu;
      memreq = dmemren_mem | dmemwen_mem;
      adv    = ihit & ~memreq;
      lu     = memren_ex && regwrite_ex != 0 && (regwrite_ex == rs_id || regwrite_ex == rt_id);
      if (!nRST || m_halted || halt_wb) return 8'b0000_0000;
      if (memreq) return dhit ? 8'b0000_1001 : 8'b0000_0000;
      if (!adv) return 8'b0000_0000;
      if (redirect_mem) return 8'b1000_1111;
      if (lu) return 8'b0001_1010;
      return 8'b1111_1000;
   endfunction

   always @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         m_halted <= 1'b0;
         m_stalls <= 0;
      end else if (!m_halted) begin
         if (halt_wb) m_halted <= 1'b1;
         else if (!model_out()[7]) m_stalls <= m_stalls + 1;
      end
   end

   always @(negedge CLK) begin
      check("model_outs_a", outs_a, model_out());
      check("model_outs_b", outs_b, model_out());
      check("model_halt_a", a_halt, m_halted);
      check("model_halt_b", b_halt, m_halted);
      check("model_cnt32", a_cnt, m_stalls);
      check("model_cnt4", b_cnt, (m_stalls > 15) ? 15 : m_stalls);
   end

   // ---------------- directed stimulus ----------------
   typedef struct packed {
      logic       ih, dh, ren, wen, mren;
      logic [4:0] rw, rs, rt;
      logic       redir, hwb;
      logic [7:0] exp_out;
      logic [7:0] exp_cnt;
   } vec_t;

   vec_t vecs [11];

   task automatic set_in(input vec_t v);
      ihit = v.ih; dhit = v.dh; dmemren_mem = v.ren; dmemwen_mem = v.wen;
      memren_ex = v.mren; regwrite_ex = v.rw; rs_id = v.rs; rt_id = v.rt;
      redirect_mem = v.redir; halt_wb = v.hwb;
   endtask

   // Called at posedge+1; returns at the following posedge+1.
   task automatic apply(input int idx, input vec_t v);
      set_in(v);
      #3;
      check($sformatf("vec%0d_outs", idx), outs_a, v.exp_out);
      @(posedge CLK); #1;
      check($sformatf("vec%0d_cnt", idx), a_cnt, v.exp_cnt);
      $display("vec %0d: outs=%b stall_cycles=%0d halt=%b", idx, outs_a, a_cnt, a_halt);
   endtask

   vec_t idle;

   initial begin
      idle = '0;
      //              ih dh rn wn mr  rw     rs     rt     rd hw  exp_out       cnt
      vecs[0]  = '{1'b1,1'b0,1'b0,1'b0,1'b0, 5'd0, 5'd0, 5'd0, 1'b0,1'b0, 8'b1111_1000, 8'd0};
      vecs[1]  = '{1'b0,1'b0,1'b0,1'b0,1'b0, 5'd0, 5'd0, 5'd0, 1'b0,1'b0, 8'b0000_0000, 8'd1};
      vecs[2]  = '{1'b1,1'b0,1'b0,1'b0,1'b1, 5'd8, 5'd3, 5'd8, 1'b0,1'b0, 8'b0001_1010, 8'd2};
      vecs[3]  = '{1'b1,1'b0,1'b0,1'b0,1'b1, 5'd0, 5'd0, 5'd0, 1'b0,1'b0, 8'b1111_1000, 8'd2};
      vecs[4]  = '{1'b1,1'b0,1'b0,1'b0,1'b1, 5'd8, 5'd8, 5'd0, 1'b1,1'b0, 8'b1000_1111, 8'd2};
      vecs[5]  = '{1'b1,1'b0,1'b1,1'b0,1'b0, 5'd0, 5'd0, 5'd0, 1'b0,1'b0, 8'b0000_0000, 8'd3};
      vecs[6]  = '{1'b0,1'b0,1'b1,1'b0,1'b0, 5'd0, 5'd0, 5'd0, 1'b0,1'b0, 8'b0000_0000, 8'd4};
      vecs[7]  = '{1'b0,1'b1,1'b1,1'b0,1'b0, 5'd0, 5'd0, 5'd0, 1'b0,1'b0, 8'b0000_1001, 8'd5};
      vecs[8]  = '{1'b1,1'b0,1'b0,1'b0,1'b0, 5'd0, 5'd0, 5'd0, 1'b0,1'b0, 8'b1111_1000, 8'd5};
      vecs[9]  = '{1'b0,1'b1,1'b0,1'b1,1'b0, 5'd0, 5'd0, 5'd0, 1'b0,1'b0, 8'b0000_1001, 8'd6};
      vecs[10] = '{1'b1,1'b0,1'b0,1'b0,1'b0, 5'd0, 5'd0, 5'd0, 1'b1,1'b0, 8'b1000_1111, 8'd6};

      nRST = 1'b0;
      set_in(idle);
      repeat (2) @(posedge CLK);
      #1;
      check("reset_outs", outs_a, 8'h00);
      check("reset_cnt", a_cnt, 0);
      check("reset_halt", a_halt, 0);
      ihit = 1'b1;
      #3 nRST = 1'b1;
      @(posedge CLK); #1;
      check("post_reset_cnt", a_cnt, 0);

      for (int i = 0; i < 11; i++) apply(i, vecs[i]);

      // Reset mid-DWAIT: outputs and counter clear immediately.
      set_in(idle);
      dmemren_mem = 1'b1;
      #2;
      check("dwait_outs", outs_a, 8'h00);
      nRST = 1'b0;
      #1;
      check("rst_dwait_outs", outs_a, 8'h00);
      check("rst_dwait_cnt32", a_cnt, 0);
      check("rst_dwait_cnt4", b_cnt, 0);
      dmemren_mem = 1'b0;
      ihit = 1'b1;
      #2 nRST = 1'b1;
      #1;
      check("rst_release_outs", outs_a, 8'b1111_1000);
      @(posedge CLK); #1;
      check("rst_release_cnt", a_cnt, 0);
      $display("reset mid-DWAIT: outs=%b stall_cycles=%0d", outs_a, a_cnt);

      // Halt: one stall cycle first, then a single halt_wb pulse.
      set_in(idle);
      @(posedge CLK); #1;
      check("pre_halt_cnt", a_cnt, 1);
      ihit = 1'b1;
      halt_wb = 1'b1;
      #3;
      check("halt_wb_outs", outs_a, 8'h00);
      @(posedge CLK); #1;
      halt_wb = 1'b0;
      check("halt_rise", a_halt, 1);
      check("halt_cnt", a_cnt, 1);
      for (int i = 0; i < 6; i++) begin
         ihit = ~ihit;
         #3;
         check("halted_outs", outs_a, 8'h00);
         @(posedge CLK); #1;
         check("halted_sticky", a_halt, 1);
         check("halted_cnt_frozen", a_cnt, 1);
         $display("halted cycle %0d: halt=%b stall_cycles=%0d", i, a_halt, a_cnt);
      end

      // Saturation: 20 cycles waiting on ihit after a fresh reset.
      nRST = 1'b0;
      set_in(idle);
      #2;
      check("rst2_halt", a_halt, 0);
      nRST = 1'b1;
      repeat (20) @(posedge CLK);
      #1;
      check("sat_cnt4", b_cnt, 15);
      check("sat_cnt32", a_cnt, 20);
      $display("saturation: cnt4=%0d cnt32=%0d", b_cnt, a_cnt);

      @(posedge CLK); #1;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
